// File: rtl/sccpu_io_bridge.sv
// Data-bus bridge for sccpu: the I/O region (addr[31:28]==IO_BASE) maps a UART
// transmitter with TX FIFO plus a free-running cycle counter; all else goes to RAM.
module sccpu_io_bridge #(
    parameter logic [3:0]  IO_BASE      = 4'hF,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [31:0] CYCLE_RESET  = '0
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        wmem,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] ram_rdata,
    output logic        ram_we,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_busy
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [31:0]   r_cycle;

    state_t        r_state, w_state_nx;
    logic [TW-1:0] r_timer, w_timer_nx;
    logic [2:0]    r_bit_idx, w_bit_idx_nx;
    logic [7:0]    r_shift, w_shift_nx;
    logic          r_tx, w_tx_nx;

    logic w_io_sel, w_push_req, w_stat_wr, w_push, w_pop, w_full, w_empty;
    logic w_unused;

    assign w_io_sel   = (addr[31:28] == IO_BASE);
    assign w_push_req = wmem & w_io_sel & (addr[3:0] == 4'h0);
    assign w_stat_wr  = wmem & w_io_sel & (addr[3:0] == 4'h4);
    assign w_full     = (r_count == C_FULL);
    assign w_empty    = (r_count == '0);
    // Fullness is judged before this edge's pop, so a push into a full FIFO drops.
    assign w_push     = w_push_req & ~w_full;

    assign ram_we  = wmem & ~w_io_sel;
    assign tx      = r_tx;
    assign tx_busy = (r_state != S_IDLE);
    assign w_unused = ^{addr[27:4], wdata[31:8]};

    always_comb begin
        rdata = '0;
        if (!w_io_sel) begin
            rdata = ram_rdata;
        end else begin
            case (addr[3:0])
                4'h4:    rdata = {28'b0, r_ovf, w_full, w_empty, tx_busy};
                4'h8:    rdata = r_cycle;
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_cycle  <= CYCLE_RESET;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_stat_wr && wdata[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_timer   <= w_timer_nx;
            r_bit_idx <= w_bit_idx_nx;
            r_shift   <= w_shift_nx;
            r_tx      <= w_tx_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_timer_nx   = r_timer;
        w_bit_idx_nx = r_bit_idx;
        w_shift_nx   = r_shift;
        w_tx_nx      = r_tx;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nx = 1'b1;
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = r_mem[r_rd_ptr];
                    w_timer_nx = T_LOAD;
                    w_state_nx = S_START;
                    w_tx_nx    = 1'b0;
                end
            end
            S_START: begin
                if (r_timer == '0) begin
                    w_state_nx   = S_DATA;
                    w_timer_nx   = T_LOAD;
                    w_bit_idx_nx = '0;
                    w_tx_nx      = r_shift[0];
                end else begin
                    w_timer_nx = r_timer - 1'b1;
                end
            end
            S_DATA: begin
                if (r_timer == '0) begin
                    w_timer_nx = T_LOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nx = S_STOP;
                        w_tx_nx    = 1'b1;
                    end else begin
                        w_bit_idx_nx = r_bit_idx + 3'd1;
                        w_shift_nx   = {1'b0, r_shift[7:1]};
                        w_tx_nx      = r_shift[1];
                    end
                end else begin
                    w_timer_nx = r_timer - 1'b1;
                end
            end
            S_STOP: begin
                if (r_timer == '0) begin
                    w_state_nx = S_IDLE;
                    w_tx_nx    = 1'b1;
                end else begin
                    w_timer_nx = r_timer - 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_tx_nx    = 1'b1;
            end
        endcase
    end

endmodule
